min_accumulate: RTL



---
 rtl/min_accumulate_if.sv | 43 ++++
 rtl/min_accumulate.sv | 139 +++++++++++++
 2 files changed

// File: rtl/min_accumulate_if.sv
// min_accumulate_if: beat input stream plus single-register result output of min_accumulate.
// Optional oindex signal present only when MINACC_INDEX_EN is defined.
`default_nettype none

interface min_accumulate_if #(
    parameter int CW = 16
);
    logic [15:0]   idata;
    logic          ivalid;
    logic          iready;
    logic          istart;
    logic          ilast;
    logic [15:0]   odata;
    logic [CW-1:0] ocount;
`ifdef MINACC_INDEX_EN
    logic [CW-1:0] oindex;
`endif
    logic          ovalid;
    logic          oready;

`ifdef MINACC_INDEX_EN
    modport master (
        output idata, ivalid, istart, ilast, oready,
        input  iready, odata, ocount, oindex, ovalid
    );
    modport slave (
        input  idata, ivalid, istart, ilast, oready,
        output iready, odata, ocount, oindex, ovalid
    );
`else
    modport master (
        output idata, ivalid, istart, ilast, oready,
        input  iready, odata, ocount, ovalid
    );
    modport slave (
        input  idata, ivalid, istart, ilast, oready,
        output iready, odata, ocount, ovalid
    );
`endif

endinterface

`default_nettype wire

// File: rtl/min_accumulate.sv
// min_accumulate: folds framed fp16 beats into a per-packet minimum with beat count.
// MINACC_INDEX_EN adds the first-occurrence index of the minimum (oindex).
`default_nettype none

module min_accumulate #(
    parameter int CW = 16
) (
    input  wire logic      aclk,
    input  wire logic      areset,
    min_accumulate_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [15:0]   C_POS_INF = 16'h7C00;
    localparam logic [CW-1:0] C_CNT_MAX = '1;
    localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [15:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   odata_q, odata_d;
    logic [CW-1:0] ocount_q, ocount_d;
    logic          ovalid_q, ovalid_d;
`ifdef MINACC_INDEX_EN
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] oindex_q, oindex_d;
`endif

    logic          w_iready;
    logic          w_beat;
    logic          w_nan;
    logic          w_less;
    logic          w_pub;
    logic [CW-1:0] w_cnt_inc;

    // Map fp16 onto an unsigned key whose order is -inf < ... < -0 < +0 < ... < +inf
    function automatic logic [15:0] fp_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    assign w_iready  = !areset && !(ovalid_q && !bus.oready);
    assign w_beat    = bus.ivalid && w_iready;
    assign w_nan     = (bus.idata[14:10] == 5'h1F) && (bus.idata[9:0] != 10'd0);
    assign w_less    = fp_key(bus.idata) < fp_key(acc_q);
    assign w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + C_CNT_ONE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef MINACC_INDEX_EN
        idx_d   = idx_q;
`endif
        w_pub   = 1'b0;

        if (w_beat) begin
            if (bus.istart) begin
                // istart always opens a fresh packet, discarding any partial fold
                acc_d   = w_nan ? C_POS_INF : bus.idata;
                cnt_d   = C_CNT_ONE;
`ifdef MINACC_INDEX_EN
                idx_d   = '0;
`endif
                w_pub   = bus.ilast;
                state_d = bus.ilast ? S_IDLE : S_ACCUM;
            end else if (state_q == S_ACCUM) begin
                cnt_d = w_cnt_inc;
                if (!w_nan && w_less) begin
                    acc_d = bus.idata;
`ifdef MINACC_INDEX_EN
                    idx_d = cnt_q;
`endif
                end
                if (bus.ilast) begin
                    w_pub   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end

        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        ocount_d = ocount_q;
`ifdef MINACC_INDEX_EN
        oindex_d = oindex_q;
`endif
        if (w_pub) begin
            ovalid_d = 1'b1;
            odata_d  = acc_d;
            ocount_d = cnt_d;
`ifdef MINACC_INDEX_EN
            oindex_d = idx_d;
`endif
        end else if (ovalid_q && bus.oready) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= S_IDLE;
            acc_q    <= C_POS_INF;
            cnt_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= 16'h0000;
            ocount_q <= '0;
`ifdef MINACC_INDEX_EN
            idx_q    <= '0;
            oindex_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            ocount_q <= ocount_d;
`ifdef MINACC_INDEX_EN
            idx_q    <= idx_d;
            oindex_q <= oindex_d;
`endif
        end
    end

    assign bus.iready = w_iready;
    assign bus.ovalid = ovalid_q;
    assign bus.odata  = odata_q;
    assign bus.ocount = ocount_q;
`ifdef MINACC_INDEX_EN
    assign bus.oindex = oindex_q;
`endif

endmodule

`default_nettype wire
